axi4l_arbiter_2to1: RTL and testbench

AXI4L_ARBITER_2TO1 -- requirements
Module: axi4l_arbiter_2to1

---
 rtl/axi4l_arbiter_2to1.sv | 186 ++++++++++++++++++
 tb/tb_axi4l_arbiter_2to1.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_arbiter_2to1.sv
// Two-master AXI4-Lite arbiter onto one slave port.
// One transaction in flight, round-robin ownership.
module axi4l_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    M0_AWVALID,
  output logic                    M0_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   M0_AWADDR,
  input  logic [2:0]              M0_AWPROT,
  input  logic                    M0_WVALID,
  output logic                    M0_WREADY,
  input  logic [DATA_WIDTH-1:0]   M0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M0_WSTRB,
  output logic                    M0_BVALID,
  input  logic                    M0_BREADY,
  output logic [1:0]              M0_BRESP,
  input  logic                    M0_ARVALID,
  output logic                    M0_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   M0_ARADDR,
  input  logic [2:0]              M0_ARPROT,
  output logic                    M0_RVALID,
  input  logic                    M0_RREADY,
  output logic [DATA_WIDTH-1:0]   M0_RDATA,
  output logic [1:0]              M0_RRESP,
  input  logic                    M1_AWVALID,
  output logic                    M1_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_AWADDR,
  input  logic [2:0]              M1_AWPROT,
  input  logic                    M1_WVALID,
  output logic                    M1_WREADY,
  input  logic [DATA_WIDTH-1:0]   M1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M1_WSTRB,
  output logic                    M1_BVALID,
  input  logic                    M1_BREADY,
  output logic [1:0]              M1_BRESP,
  input  logic                    M1_ARVALID,
  output logic                    M1_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_ARADDR,
  input  logic [2:0]              M1_ARPROT,
  output logic                    M1_RVALID,
  input  logic                    M1_RREADY,
  output logic [DATA_WIDTH-1:0]   M1_RDATA,
  output logic [1:0]              M1_RRESP,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [ADDR_WIDTH-1:0]   S_AWADDR,
  output logic [2:0]              S_AWPROT,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  output logic [DATA_WIDTH-1:0]   S_WDATA,
  output logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  input  logic [1:0]              S_BRESP,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  output logic [ADDR_WIDTH-1:0]   S_ARADDR,
  output logic [2:0]              S_ARPROT,
  input  logic                    S_RVALID,
  output logic                    S_RREADY,
  input  logic [DATA_WIDTH-1:0]   S_RDATA,
  input  logic [1:0]              S_RRESP,
  output logic [1:0]              GRANT,
  output logic                    BUSY
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_RESP
  } state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_q;
  logic       aw_done_q;
  logic       w_done_q;

  logic own, req0, req1, win, win_aw;
  logic in_wr, in_wrr, in_rd, in_rdr;
  logic aw_en, w_en, sel0, sel1;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign own    = grant_q[1];
  assign GRANT  = grant_q;
  assign BUSY   = (state_q != IDLE);
  assign req0   = M0_AWVALID | M0_ARVALID;
  assign req1   = M1_AWVALID | M1_ARVALID;
  // on a tie, the master not served last wins
  assign win    = (req0 & req1) ? ~last_q : req1;
  assign win_aw = win ? M1_AWVALID : M0_AWVALID;

  assign in_wr  = (state_q == WR);
  assign in_wrr = (state_q == WR_RESP);
  assign in_rd  = (state_q == RD);
  assign in_rdr = (state_q == RD_RESP);
  assign aw_en  = in_wr & ~aw_done_q;
  assign w_en   = in_wr & ~w_done_q;
  assign sel0   = BUSY & ~own;
  assign sel1   = BUSY & own;

  assign S_AWVALID = aw_en & (own ? M1_AWVALID : M0_AWVALID);
  assign S_AWADDR  = !aw_en ? '0 : own ? M1_AWADDR : M0_AWADDR;
  assign S_AWPROT  = !aw_en ? '0 : own ? M1_AWPROT : M0_AWPROT;
  assign S_WVALID  = w_en & (own ? M1_WVALID : M0_WVALID);
  assign S_WDATA   = !w_en ? '0 : own ? M1_WDATA : M0_WDATA;
  assign S_WSTRB   = !w_en ? '0 : own ? M1_WSTRB : M0_WSTRB;
  assign S_BREADY  = in_wrr & (own ? M1_BREADY : M0_BREADY);
  assign S_ARVALID = in_rd & (own ? M1_ARVALID : M0_ARVALID);
  assign S_ARADDR  = !in_rd ? '0 : own ? M1_ARADDR : M0_ARADDR;
  assign S_ARPROT  = !in_rd ? '0 : own ? M1_ARPROT : M0_ARPROT;
  assign S_RREADY  = in_rdr & (own ? M1_RREADY : M0_RREADY);

  assign M0_AWREADY = aw_en & sel0 & S_AWREADY;
  assign M0_WREADY  = w_en & sel0 & S_WREADY;
  assign M0_BVALID  = in_wrr & sel0 & S_BVALID;
  assign M0_BRESP   = (in_wrr & sel0) ? S_BRESP : '0;
  assign M0_ARREADY = in_rd & sel0 & S_ARREADY;
  assign M0_RVALID  = in_rdr & sel0 & S_RVALID;
  assign M0_RDATA   = (in_rdr & sel0) ? S_RDATA : '0;
  assign M0_RRESP   = (in_rdr & sel0) ? S_RRESP : '0;

  assign M1_AWREADY = aw_en & sel1 & S_AWREADY;
  assign M1_WREADY  = w_en & sel1 & S_WREADY;
  assign M1_BVALID  = in_wrr & sel1 & S_BVALID;
  assign M1_BRESP   = (in_wrr & sel1) ? S_BRESP : '0;
  assign M1_ARREADY = in_rd & sel1 & S_ARREADY;
  assign M1_RVALID  = in_rdr & sel1 & S_RVALID;
  assign M1_RDATA   = (in_rdr & sel1) ? S_RDATA : '0;
  assign M1_RRESP   = (in_rdr & sel1) ? S_RRESP : '0;

  assign aw_hs = S_AWVALID & S_AWREADY;
  assign w_hs  = S_WVALID & S_WREADY;
  assign b_hs  = S_BVALID & S_BREADY;
  assign ar_hs = S_ARVALID & S_ARREADY;
  assign r_hs  = S_RVALID & S_RREADY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            grant_q <= win ? 2'b10 : 2'b01;
            state_q <= win_aw ? WR : RD;
          end
        end
        WR: begin
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= own;
          end
        end
        RD: begin
          if (ar_hs) state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (r_hs) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= own;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_arbiter_2to1.sv
// Bench for axi4l_arbiter_2to1: directed scenarios,
// then random traffic against a round-robin ownership model.
module tb_axi4l_arbiter_2to1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  m_awvalid, m_wvalid, m_bready;
  logic [1:0]  m_arvalid, m_rready;
  logic [31:0] m_awaddr [2];
  logic [31:0] m_araddr [2];
  logic [31:0] m_wdata [2];
  logic [2:0]  m_awprot [2];
  logic [2:0]  m_arprot [2];
  logic [3:0]  m_wstrb [2];
  wire  [1:0]  m_awready, m_wready, m_bvalid;
  wire  [1:0]  m_arready, m_rvalid;
  wire  [1:0]  m_bresp [2];
  wire  [1:0]  m_rresp [2];
  wire  [31:0] m_rdata [2];

  logic        s_awready, s_wready, s_bvalid;
  logic        s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  wire         s_awvalid, s_wvalid, s_bready;
  wire         s_arvalid, s_rready;
  wire  [31:0] s_awaddr, s_araddr, s_wdata;
  wire  [2:0]  s_awprot, s_arprot;
  wire  [3:0]  s_wstrb;
  wire  [1:0]  grant;
  wire         busy;

  axi4l_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RSTN(rstn),
    .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(m_awready[0]),
    .M0_AWADDR(m_awaddr[0]), .M0_AWPROT(m_awprot[0]),
    .M0_WVALID(m_wvalid[0]), .M0_WREADY(m_wready[0]),
    .M0_WDATA(m_wdata[0]), .M0_WSTRB(m_wstrb[0]),
    .M0_BVALID(m_bvalid[0]), .M0_BREADY(m_bready[0]),
    .M0_BRESP(m_bresp[0]),
    .M0_ARVALID(m_arvalid[0]), .M0_ARREADY(m_arready[0]),
    .M0_ARADDR(m_araddr[0]), .M0_ARPROT(m_arprot[0]),
    .M0_RVALID(m_rvalid[0]), .M0_RREADY(m_rready[0]),
    .M0_RDATA(m_rdata[0]), .M0_RRESP(m_rresp[0]),
    .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(m_awready[1]),
    .M1_AWADDR(m_awaddr[1]), .M1_AWPROT(m_awprot[1]),
    .M1_WVALID(m_wvalid[1]), .M1_WREADY(m_wready[1]),
    .M1_WDATA(m_wdata[1]), .M1_WSTRB(m_wstrb[1]),
    .M1_BVALID(m_bvalid[1]), .M1_BREADY(m_bready[1]),
    .M1_BRESP(m_bresp[1]),
    .M1_ARVALID(m_arvalid[1]), .M1_ARREADY(m_arready[1]),
    .M1_ARADDR(m_araddr[1]), .M1_ARPROT(m_arprot[1]),
    .M1_RVALID(m_rvalid[1]), .M1_RREADY(m_rready[1]),
    .M1_RDATA(m_rdata[1]), .M1_RRESP(m_rresp[1]),
    .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_AWADDR(s_awaddr), .S_AWPROT(s_awprot),
    .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_WDATA(s_wdata), .S_WSTRB(s_wstrb),
    .S_BVALID(s_bvalid), .S_BREADY(s_bready),
    .S_BRESP(s_bresp),
    .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
    .S_ARADDR(s_araddr), .S_ARPROT(s_arprot),
    .S_RVALID(s_rvalid), .S_RREADY(s_rready),
    .S_RDATA(s_rdata), .S_RRESP(s_rresp),
    .GRANT(grant), .BUSY(busy)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag, input int x);
    chk(tag, {m_awready[x], m_wready[x], m_bvalid[x],
              m_arready[x], m_rvalid[x], m_bresp[x],
              m_rresp[x], m_rdata[x]}, 64'd0);
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    m_arvalid = '0; m_rready = '0;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_araddr[i] = '0;
      m_wdata[i] = '0; m_wstrb[i] = '0;
      m_awprot[i] = '0; m_arprot[i] = '0;
    end
    s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_arready = 0; s_rvalid = 0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
  endtask

  // lone-master read, checked cycle by cycle
  task automatic do_read(input int m, input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [1:0] rs);
    tick();
    m_arvalid[m] = 1; m_araddr[m] = a;
    m_rready[m] = 1; s_arready = 1;
    @(negedge clk);
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_s_arvalid", s_arvalid, 0);
    tick();
    @(negedge clk);
    chk("rd_grant", grant, 64'd1 << m);
    chk("rd_s_arvalid", s_arvalid, 1);
    chk("rd_s_araddr", s_araddr, a);
    chk("rd_m_arready", m_arready, 64'd1 << m);
    quiet("rd_other_quiet_ar", 1 - m);
    tick();
    m_arvalid[m] = 0;
    s_rvalid = 1; s_rdata = d; s_rresp = rs;
    @(negedge clk);
    chk("rd_m_rvalid", m_rvalid, 64'd1 << m);
    chk("rd_m_rdata", m_rdata[m], d);
    chk("rd_m_rresp", m_rresp[m], rs);
    chk("rd_s_rready", s_rready, 1);
    quiet("rd_other_quiet_r", 1 - m);
    tick();
    s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    m_rready[m] = 0; s_arready = 0;
    @(negedge clk);
    chk("rd_done_grant", grant, 0);
    chk("rd_done_rvalid", m_rvalid, 0);
  endtask

  // random-phase model and bench state
  logic       mbusy, nbusy, done, issue;
  int         mown, nown, mlast;
  int         mst [2];
  int         cnt [2];
  logic [1:0] req, mhs_aw, mhs_w, mhs_ar, mhs_b, mhs_r;
  logic       saw, sw, sar, sb, sr;
  logic       s_aw_got, s_w_got, s_ar_got;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // M0 write, OKAY response
    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_valid", {s_awvalid, s_wvalid, s_arvalid}, 0);
    chk("rst_s_ready", {s_bready, s_rready}, 0);
    tick();
    m_awvalid[0] = 1; m_awaddr[0] = 32'h10;
    m_wvalid[0] = 1; m_wdata[0] = 32'hA5A5A5A5;
    m_wstrb[0] = 4'hF; m_bready[0] = 1;
    s_awready = 1; s_wready = 1;
    @(negedge clk);
    chk("w1_req_s_awvalid", s_awvalid, 0);
    chk("w1_req_grant", grant, 0);
    quiet("w1_idle_m0_quiet", 0);
    tick();
    @(negedge clk);
    chk("w1_s_awvalid", s_awvalid, 1);
    chk("w1_s_wvalid", s_wvalid, 1);
    chk("w1_s_awaddr", s_awaddr, 32'h10);
    chk("w1_s_wdata", s_wdata, 32'hA5A5A5A5);
    chk("w1_s_wstrb", s_wstrb, 4'hF);
    chk("w1_grant", grant, 2'b01);
    chk("w1_busy", busy, 1);
    chk("w1_m_awready", m_awready, 2'b01);
    chk("w1_m_wready", m_wready, 2'b01);
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0;
    s_bvalid = 1; s_bresp = 2'b00;
    @(negedge clk);
    chk("w1_resp_s_awvalid", s_awvalid, 0);
    chk("w1_m_bvalid", m_bvalid, 2'b01);
    chk("w1_m_bresp", m_bresp[0], 0);
    chk("w1_s_bready", s_bready, 1);
    quiet("w1_m1_quiet", 1);
    tick();
    s_bvalid = 0;
    @(negedge clk);
    chk("w1_end_grant", grant, 2'b00);
    chk("w1_end_busy", busy, 0);
    chk("w1_end_bvalid", m_bvalid, 0);

    // simultaneous reads, three rounds
    do_reset();
    tick();
    m_arvalid = 2'b11; m_rready = 2'b11;
    m_araddr[0] = 32'h100; m_araddr[1] = 32'h200;
    s_arready = 1;
    for (int r = 0; r < 3; r++) begin
      int o;
      o = (r == 1) ? 1 : 0;
      @(negedge clk);
      chk("rr_idle_busy", busy, 0);
      chk("rr_idle_grant", grant, 0);
      tick();
      @(negedge clk);
      chk("rr_grant", grant, 64'd1 << o);
      chk("rr_s_araddr", s_araddr, o ? 32'h200 : 32'h100);
      chk("rr_m_arready", m_arready, 64'd1 << o);
      tick();
      m_arvalid[o] = 0;
      s_rvalid = 1; s_rdata = 32'h1000 + r;
      @(negedge clk);
      chk("rr_m_rvalid", m_rvalid, 64'd1 << o);
      chk("rr_m_rdata", m_rdata[o], 32'h1000 + r);
      tick();
      s_rvalid = 0;
      m_arvalid[o] = 1;
    end

    // W three cycles ahead of AW on M1
    do_reset();
    tick();
    m_wvalid[1] = 1; m_wdata[1] = 32'h5555AAAA;
    m_wstrb[1] = 4'h3; m_bready[1] = 1;
    s_wready = 1; s_awready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wf_early_busy", busy, 0);
      chk("wf_early_s_wvalid", s_wvalid, 0);
      tick();
    end
    m_awvalid[1] = 1; m_awaddr[1] = 32'h44;
    tick();
    @(negedge clk);
    chk("wf_grant", grant, 2'b10);
    chk("wf_s_wvalid", s_wvalid, 1);
    chk("wf_s_wdata", s_wdata, 32'h5555AAAA);
    chk("wf_m_wready", m_wready, 2'b10);
    chk("wf_s_awvalid", s_awvalid, 1);
    tick();
    m_wvalid[1] = 0;
    @(negedge clk);
    chk("wf_w_masked", s_wvalid, 0);
    chk("wf_no_resp_yet", s_bready, 0);
    chk("wf_still_busy", busy, 1);
    tick();
    s_awready = 1;
    @(negedge clk);
    chk("wf_still_no_resp", s_bready, 0);
    chk("wf_m_awready", m_awready, 2'b10);
    chk("wf_s_awaddr", s_awaddr, 32'h44);
    tick();
    m_awvalid[1] = 0;
    s_bvalid = 1; s_bresp = 2'b00;
    @(negedge clk);
    chk("wf_m_bvalid", m_bvalid, 2'b10);
    chk("wf_s_bready", s_bready, 1);
    tick();
    s_bvalid = 0;
    @(negedge clk);
    chk("wf_single_b", m_bvalid, 0);
    chk("wf_end_grant", grant, 0);

    // M0 AW and AR together: write then read
    do_reset();
    tick();
    m_awvalid[0] = 1; m_awaddr[0] = 32'h80;
    m_wvalid[0] = 1; m_wdata[0] = 32'h12345678;
    m_wstrb[0] = 4'hF; m_bready[0] = 1;
    m_arvalid[0] = 1; m_araddr[0] = 32'h84;
    m_rready[0] = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    tick();
    @(negedge clk);
    chk("wr1st_grant", grant, 2'b01);
    chk("wr1st_s_awvalid", s_awvalid, 1);
    chk("wr1st_s_arvalid", s_arvalid, 0);
    quiet("wr1st_m1_quiet_a", 1);
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0;
    s_bvalid = 1;
    @(negedge clk);
    chk("wr1st_m_bvalid", m_bvalid, 2'b01);
    chk("wr1st_s_arvalid_b", s_arvalid, 0);
    quiet("wr1st_m1_quiet_b", 1);
    tick();
    s_bvalid = 0;
    @(negedge clk);
    chk("wr1st_gap_busy", busy, 0);
    tick();
    @(negedge clk);
    chk("rd2nd_s_arvalid", s_arvalid, 1);
    chk("rd2nd_s_araddr", s_araddr, 32'h84);
    chk("rd2nd_grant", grant, 2'b01);
    quiet("rd2nd_m1_quiet_a", 1);
    tick();
    m_arvalid[0] = 0;
    s_rvalid = 1; s_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rd2nd_m_rdata", m_rdata[0], 32'hCAFEF00D);
    quiet("rd2nd_m1_quiet_r", 1);
    tick();
    s_rvalid = 0;
    @(negedge clk);
    chk("rd2nd_end_busy", busy, 0);

    // reset during WR_RESP
    do_reset();
    do_read(0, 32'h8, 32'h1, 2'b00);
    tick();
    m_awvalid[0] = 1; m_wvalid[0] = 1;
    m_awaddr[0] = 32'hC; m_wdata[0] = 32'h77;
    s_awready = 1; s_wready = 1;
    tick();
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0;
    s_bvalid = 1;
    @(negedge clk);
    chk("rst_mid_bvalid", m_bvalid, 2'b01);
    #2 rstn = 0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_grant", grant, 0);
    chk("rst_async_bvalid", m_bvalid, 0);
    tick();
    tick();
    rstn = 1;
    m_bready[0] = 1;
    @(negedge clk);
    chk("rst_rel_bvalid", m_bvalid, 0);
    chk("rst_rel_grant", grant, 0);
    chk("rst_rel_s_bready", s_bready, 0);
    tick();
    s_bvalid = 0;
    m_arvalid = 2'b11;
    @(negedge clk);
    chk("rst_tie_idle", grant, 0);
    tick();
    @(negedge clk);
    chk("rst_tie_m0_wins", grant, 2'b01);

    // read error response with data
    do_reset();
    do_read(0, 32'h20, 32'hDEADBEEF, 2'b10);

    // random traffic vs ownership model
    do_reset();
    mbusy = 0; mlast = 1; mown = 0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    mst[0] = 0; mst[1] = 0;
    cnt[0] = 0; cnt[1] = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      issue = (cyc < 900);
      if (!issue && mst[0] == 0 && mst[1] == 0 && !mbusy)
        break;
      @(negedge clk);
      if (mbusy) begin
        chk("rnd_grant", grant, 64'd1 << mown);
        quiet("rnd_nonowner_quiet", 1 - mown);
      end else begin
        chk("rnd_idle_grant", grant, 0);
        chk("rnd_idle_s", {s_awvalid, s_wvalid, s_arvalid,
                           s_bready, s_rready}, 0);
        quiet("rnd_idle_m0", 0);
        quiet("rnd_idle_m1", 1);
      end
      saw = s_awvalid & s_awready;
      sw  = s_wvalid & s_wready;
      sar = s_arvalid & s_arready;
      sb  = s_bvalid & s_bready;
      sr  = s_rvalid & s_rready;
      if (saw) begin
        chk("rnd_awaddr", s_awaddr, m_awaddr[mown]);
        chk("rnd_awprot", s_awprot, m_awprot[mown]);
      end
      if (sw) begin
        chk("rnd_wdata", s_wdata, m_wdata[mown]);
        chk("rnd_wstrb", s_wstrb, m_wstrb[mown]);
      end
      if (sar) begin
        chk("rnd_araddr", s_araddr, m_araddr[mown]);
        chk("rnd_arprot", s_arprot, m_arprot[mown]);
      end
      if (mbusy && s_bvalid)
        chk("rnd_bready_fwd", s_bready, m_bready[mown]);
      if (mbusy && s_rvalid)
        chk("rnd_rready_fwd", s_rready, m_rready[mown]);
      mhs_aw = m_awvalid & m_awready;
      mhs_w  = m_wvalid & m_wready;
      mhs_ar = m_arvalid & m_arready;
      mhs_b  = m_bvalid & m_bready;
      mhs_r  = m_rvalid & m_rready;
      for (int x = 0; x < 2; x++) begin
        if (mhs_b[x]) begin
          chk("rnd_b_owner", x, mown);
          chk("rnd_bresp", m_bresp[x], s_bresp);
        end
        if (mhs_r[x]) begin
          chk("rnd_r_owner", x, mown);
          chk("rnd_rdata", m_rdata[x], s_rdata);
          chk("rnd_rresp", m_rresp[x], s_rresp);
        end
      end
      nbusy = mbusy;
      nown = mown;
      if (!mbusy) begin
        req = m_awvalid | m_arvalid;
        if (req != 2'b00) begin
          nown = (req == 2'b11) ? 1 - mlast : (req[1] ? 1 : 0);
          nbusy = 1;
        end
      end else begin
        done = (s_bvalid && m_bready[mown]) ||
               (s_rvalid && m_rready[mown]);
        if (done) begin
          nbusy = 0;
          mlast = mown;
        end
      end
      @(posedge clk);
      #1;
      mbusy = nbusy;
      mown = nown;
      for (int x = 0; x < 2; x++) begin
        if (mhs_aw[x]) m_awvalid[x] = 0;
        if (mhs_w[x])  m_wvalid[x] = 0;
        if (mhs_ar[x]) m_arvalid[x] = 0;
        if (mhs_b[x] || mhs_r[x]) begin
          mst[x] = 0;
          cnt[x]++;
        end
        if (mst[x] == 0 && issue && $urandom_range(0, 2) == 0) begin
          mst[x] = 1;
          if ($urandom_range(0, 1) == 1) begin
            m_awvalid[x] = 1; m_wvalid[x] = 1;
            m_awaddr[x] = $urandom;
            m_awprot[x] = 3'($urandom);
            m_wdata[x] = $urandom;
            m_wstrb[x] = 4'($urandom);
          end else begin
            m_arvalid[x] = 1;
            m_araddr[x] = $urandom;
            m_arprot[x] = 3'($urandom);
          end
        end
        m_bready[x] = 1'($urandom);
        m_rready[x] = 1'($urandom);
      end
      if (sb) begin
        s_bvalid = 0; s_aw_got = 0; s_w_got = 0;
      end
      if (sr) begin
        s_rvalid = 0; s_ar_got = 0;
      end
      if (saw) s_aw_got = 1;
      if (sw)  s_w_got = 1;
      if (sar) s_ar_got = 1;
      if (!s_bvalid && s_aw_got && s_w_got &&
          $urandom_range(0, 1) == 1) begin
        s_bvalid = 1;
        s_bresp = 2'($urandom);
      end
      if (!s_rvalid && s_ar_got && $urandom_range(0, 1) == 1) begin
        s_rvalid = 1;
        s_rdata = $urandom;
        s_rresp = 2'($urandom);
      end
      s_awready = 1'($urandom);
      s_wready = 1'($urandom);
      s_arready = 1'($urandom);
    end
    chk("rnd_drained",
        (mst[0] != 0 || mst[1] != 0 || mbusy), 0);
    chk("rnd_m0_served", cnt[0] > 0, 1);
    chk("rnd_m1_served", cnt[1] > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
